// File: rtl/sensor_cond_pkg.sv
// Shared constants and helpers for the sensor conditioning front end.
// Optional feature macro used by sensor_condition: TORQUE_DEADBAND_EN.
package sensor_cond_pkg;

  // Sample width shared by torque and current inputs
  localparam int SAMPLE_W = 12;

  // Exponential average shifts: current follows faster than torque
  localparam int C_SHIFT = 2;
  localparam int T_SHIFT = 4;

  // Accumulator widths: sample width plus shift never wraps in steady state
  localparam int C_ACC_W = SAMPLE_W + C_SHIFT;
  localparam int T_ACC_W = SAMPLE_W + T_SHIFT;

  // Cadence timer widths (full span and shortened simulation span)
  localparam int CAD_CNT_W      = 25;
  localparam int CAD_CNT_W_FAST = 15;

  // Default torque deadband offset
  localparam logic [11:0] TORQUE_MIN_DEF = 12'h380;

  // Clamp a 15-bit unsigned value into 12 bits
  function automatic logic [11:0] sat12(input logic [14:0] v);
    if (v > 15'h0FFF) begin
      return 12'hFFF;
    end
    return v[11:0];
  endfunction

endpackage

// File: rtl/exp_avg.sv
// Exponential moving average: acc <= acc - (acc >> SHIFT) + sample on each
// valid strobe; the average is the accumulator with SHIFT fraction bits dropped.
// vld_i is a single-cycle strobe with no back-pressure: every cycle with
// vld_i=1 consumes din_i, cycles with vld_i=0 leave the accumulator untouched.
module exp_avg #(
  parameter int IN_W  = 12,
  parameter int SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [IN_W-1:0] din_i,
  output logic [IN_W-1:0] avg_o
);

  localparam int ACC_W = IN_W + SHIFT;

  logic [ACC_W-1:0] acc_q, acc_d;

  // Next accumulator value: leak 1/2^SHIFT and add the new sample
  always_comb begin
    acc_d = acc_q;
    if (vld_i) begin
      acc_d = acc_q - (acc_q >> SHIFT) + {{SHIFT{1'b0}}, din_i};
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign avg_o = acc_q[ACC_W-1:SHIFT];

endmodule

// File: rtl/sensor_condition.sv
// Sensor conditioning for the PID loop: cadence synchroniser and timeout
// timer, torque/current averaging, and the registered target/error pipeline.
// Optional feature: define TORQUE_DEADBAND_EN to subtract TORQUE_MIN from the
// averaged torque before scaling.
module sensor_condition
  import sensor_cond_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b0,
  parameter logic [11:0] TORQUE_MIN = TORQUE_MIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cadence_raw,
  input  logic [11:0] torque,
  input  logic        torque_vld,
  input  logic [11:0] curr,
  input  logic        curr_vld,
  input  logic [2:0]  scale,
  output logic [12:0] error,
  output logic        not_pedaling,
  output logic [7:0]  cad_per
);

  localparam int CNT_MSB = FAST_SIM ? (CAD_CNT_W_FAST - 1) : (CAD_CNT_W - 1);
  localparam logic [CAD_CNT_W-1:0] CAD_MAX =
    FAST_SIM ? {{(CAD_CNT_W-CAD_CNT_W_FAST){1'b0}}, {CAD_CNT_W_FAST{1'b1}}}
             : {CAD_CNT_W{1'b1}};

`ifdef TORQUE_DEADBAND_EN
  localparam logic [11:0] DEADBAND = TORQUE_MIN;
`else
  // Deadband disabled: offset is forced to zero so t_off equals avg_torque
  localparam logic [11:0] DEADBAND = TORQUE_MIN & 12'h000;
`endif

  logic                 sync1_q, sync2_q, edge_q;
  logic                 cad_rise;
  logic [CAD_CNT_W-1:0] cad_cnt_q, cad_cnt_d;
  logic                 np_q, np_d;
  logic [7:0]           cad_per_q, cad_per_d;
  logic [11:0]          avg_curr, avg_torque;
  logic [11:0]          t_off;
  logic [14:0]          prod;
  logic [11:0]          target_q, target_d;
  logic [12:0]          error_q, error_d;

  // Two-flop synchroniser plus edge flop for the asynchronous cadence input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= cadence_raw;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign cad_rise = sync2_q & ~edge_q;

  // Cadence timer and pedaling status; a rise at the saturated count only restarts timing
  always_comb begin
    cad_cnt_d = cad_cnt_q;
    np_d      = np_q;
    cad_per_d = cad_per_q;
    if (cad_rise) begin
      cad_cnt_d = '0;
    end else if (cad_cnt_q != CAD_MAX) begin
      cad_cnt_d = cad_cnt_q + 1'b1;
    end
    if (cad_cnt_q == CAD_MAX) begin
      np_d = 1'b1;
    end else if (cad_rise) begin
      np_d      = 1'b0;
      cad_per_d = cad_cnt_q[CNT_MSB -: 8];
    end
  end

  // Cadence timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cad_cnt_q <= '0;
      np_q      <= 1'b1;
      cad_per_q <= '0;
    end else begin
      cad_cnt_q <= cad_cnt_d;
      np_q      <= np_d;
      cad_per_q <= cad_per_d;
    end
  end

  exp_avg #(.IN_W(SAMPLE_W), .SHIFT(C_SHIFT)) u_curr_avg (
    .clk   (clk),
    .rst   (rst),
    .vld_i (curr_vld),
    .din_i (curr),
    .avg_o (avg_curr)
  );

  exp_avg #(.IN_W(SAMPLE_W), .SHIFT(T_SHIFT)) u_torque_avg (
    .clk   (clk),
    .rst   (rst),
    .vld_i (torque_vld),
    .din_i (torque),
    .avg_o (avg_torque)
  );

  // Target and error next-state: scaled torque, clamped, minus averaged current
  always_comb begin
    t_off    = (avg_torque > DEADBAND) ? (avg_torque - DEADBAND) : 12'h000;
    prod     = {3'b000, t_off} * {12'h000, scale};
    target_d = np_q ? 12'h000 : sat12(prod >> 2);
    error_d  = {1'b0, target_q} - {1'b0, avg_curr};
  end

  // Target and error pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      error_q  <= '0;
    end else begin
      target_q <= target_d;
      error_q  <= error_d;
    end
  end

  assign error        = error_q;
  assign not_pedaling = np_q;
  assign cad_per      = cad_per_q;

endmodule

// File: tb/tb_sensor_condition.sv
// Directed bench for sensor_condition (FAST_SIM=1). Expected values are
// hand-computed constants; build with TORQUE_DEADBAND_EN to cover the deadband.
module tb_sensor_condition;

  logic        clk;
  logic        rst;
  logic        cadence_raw;
  logic [11:0] torque;
  logic        torque_vld;
  logic [11:0] curr;
  logic        curr_vld;
  logic [2:0]  scale;
  logic [12:0] error;
  logic        not_pedaling;
  logic [7:0]  cad_per;

  int passed;
  int total;
  int cyc;
  int e1;
  int e2;

  sensor_condition #(.FAST_SIM(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cadence_raw  (cadence_raw),
    .torque       (torque),
    .torque_vld   (torque_vld),
    .curr         (curr),
    .curr_vld     (curr_vld),
    .scale        (scale),
    .error        (error),
    .not_pedaling (not_pedaling),
    .cad_per      (cad_per)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_curr(input logic [11:0] v);
    curr     = v;
    curr_vld = 1'b1;
    tick();
    curr_vld = 1'b0;
    tick();
  endtask

  task automatic pulse_torque(input logic [11:0] v);
    torque     = v;
    torque_vld = 1'b1;
    tick();
    torque_vld = 1'b0;
    tick();
  endtask

  // Raw rise, then three edges until the timer acts on it; returns that edge's cycle
  task automatic cad_pulse(output int at_cyc);
    cadence_raw = 1'b1;
    tick();
    tick();
    tick();
    at_cyc      = cyc;
    cadence_raw = 1'b0;
  endtask

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    cadence_raw = 1'b0;
    torque      = '0;
    torque_vld  = 1'b0;
    curr        = '0;
    curr_vld    = 1'b0;
    scale       = '0;

    // Reset state
    tick();
    tick();
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_np", 32'(not_pedaling), 32'h1);
    chk("rst_cad_per", 32'(cad_per), 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_error", 32'(error), 32'h0);
    chk("idle_np", 32'(not_pedaling), 32'h1);

    // Current average while not pedaling: error = -avg_curr, 2-clk latency
    curr     = 12'h800;
    curr_vld = 1'b1;
    tick();
    curr_vld = 1'b0;
    chk("curr_lat_early", 32'(error), 32'h0);
    tick();
    chk("curr_avg1", 32'(error), 32'h1E00);
    pulse_curr(12'h800);
    chk("curr_avg2", 32'(error), 32'h1C80);

    // Cadence rise with timer saturated: restarts count, stays not pedaling
    while (cyc < 33000) tick();
    chk("sat_np", 32'(not_pedaling), 32'h1);
    cad_pulse(e1);
    chk("max_rise_cnt", 32'(dut.cad_cnt_q), 32'h0);
    chk("max_rise_np", 32'(not_pedaling), 32'h1);
    chk("max_rise_per", 32'(cad_per), 32'h0);

    // Second rise 10000 clks later: pedaling, period = 9999 >> 7 = 78
    while (cyc < e1 + 9997) tick();
    cad_pulse(e2);
    chk("ped_np", 32'(not_pedaling), 32'h0);
    chk("ped_cad_per", 32'(cad_per), 32'd78);

    // Pedaling, scale 0, avg_curr saturated -> error -4095
    for (int i = 0; i < 60; i++) pulse_curr(12'hFFF);
    tick();
    chk("neg_full_scale", 32'(error), 32'h1001);

    // Torque 0x580, scale 4
    scale = 3'd4;
    for (int i = 0; i < 300; i++) pulse_torque(12'h580);
    tick();
`ifdef TORQUE_DEADBAND_EN
    chk("torque_580_s4", 32'(error), 32'h1201);
`else
    chk("torque_580_s4", 32'(error), 32'h1581);
`endif

    // Torque full scale, scale 7 -> target clamps to 0xFFF
    scale = 3'd7;
    for (int i = 0; i < 400; i++) pulse_torque(12'hFFF);
    tick();
    chk("torque_clamp", 32'(error), 32'h0);

    // Scale change -> target one clk, error the next
    scale = 3'd1;
    tick();
    chk("scale_lat_early", 32'(error), 32'h0);
    tick();
`ifdef TORQUE_DEADBAND_EN
    chk("scale1", 32'(error), 32'h1320);
`else
    chk("scale1", 32'(error), 32'h1400);
`endif

    // Cadence timeout: count hits max 32767 clks after the last rise
    while (cyc < e2 + 32767) tick();
    chk("timeout_before", 32'(not_pedaling), 32'h0);
    tick();
    chk("timeout_np", 32'(not_pedaling), 32'h1);
    chk("timeout_cad_per", 32'(cad_per), 32'd78);
    tick();
    tick();
    chk("np_to_error", 32'(error), 32'h1001);

    // Reset mid-operation clears every register
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_error", 32'(error), 32'h0);
    chk("midrst_np", 32'(not_pedaling), 32'h1);
    chk("midrst_cad_per", 32'(cad_per), 32'h0);
    repeat (3) tick();
    chk("midrst_acc_clear", 32'(error), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
